branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 116 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped branch target buffer with saturating
// direction counters and resolved/mispredicted branch statistics.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   lookup_pc         IF-stage PC; pred_hit/pred_taken/pred_target are
//                     combinational from the registered table
//   upd_valid/upd_pc/upd_taken/upd_target/upd_pred_taken
//                     ID-stage resolution; trains the table and the stats
//   clear             invalidate the whole table in one cycle
//   branch_cnt        resolved-branch count (saturating)
//   mispred_cnt       mispredicted-branch count (saturating)
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int CTR_BITS  = 2,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic             clear,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [ENTRIES-1:0]               validQ;
  logic [ENTRIES-1:0][TAG_W-1:0]    tagQ;
  logic [ENTRIES-1:0][31:0]         targetQ;
  logic [ENTRIES-1:0][CTR_BITS-1:0] ctrQ;
  logic [CNT_W-1:0]                 branchCntQ;
  logic [CNT_W-1:0]                 mispredCntQ;

  logic [IDX_W-1:0] lkIdx, upIdx;
  logic [TAG_W-1:0] lkTag, upTag;
  logic             upHit;
  logic [CTR_BITS-1:0] upCtr;

  // PC bits outside the index/tag fields are intentionally ignored.
  logic unusedPcBits;
  assign unusedPcBits = ^{lookup_pc, upd_pc};

  assign lkIdx = lookup_pc[IDX_W+1:2];
  assign lkTag = lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign upIdx = upd_pc[IDX_W+1:2];
  assign upTag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);
  assign upCtr = ctrQ[upIdx];

  assign pred_hit = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);

  generate
    if (PRED_MODE == 1) begin : gDyn
      assign pred_taken = pred_hit && ctrQ[lkIdx][CTR_BITS-1];
    end else begin : gStatic
      assign pred_taken = 1'b0;
    end
  endgenerate

  assign pred_target = pred_taken ? targetQ[lkIdx] : lookup_pc + 32'd4;

  assign branch_cnt  = branchCntQ;
  assign mispred_cnt = mispredCntQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ      <= '0;
      tagQ        <= '0;
      targetQ     <= '0;
      for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= CTR_WNT;
      branchCntQ  <= '0;
      mispredCntQ <= '0;
    end else begin
      // Statistics count every resolution, even when the table is cleared.
      if (upd_valid) begin
        if (branchCntQ != '1) branchCntQ <= branchCntQ + 1'b1;
        if ((upd_pred_taken != upd_taken) && (mispredCntQ != '1))
          mispredCntQ <= mispredCntQ + 1'b1;
      end
      if (clear) begin
        validQ <= '0;
        for (int i = 0; i < ENTRIES; i++) ctrQ[i] <= CTR_WNT;
      end else if (upd_valid) begin
        if (upHit) begin
          if (upd_taken) begin
            if (upCtr != CTR_MAX) ctrQ[upIdx] <= upCtr + 1'b1;
            targetQ[upIdx] <= upd_target;
          end else if (upCtr != '0) begin
            ctrQ[upIdx] <= upCtr - 1'b1;
          end
        end else if (upd_taken) begin
          // Miss on a taken branch replaces whatever lived at this index.
          validQ[upIdx]  <= 1'b1;
          tagQ[upIdx]    <= upTag;
          targetQ[upIdx] <= upd_target;
          ctrQ[upIdx]    <= CTR_WT;
        end
      end
    end
  end

endmodule
